// File: rtl/mac_pkg.sv
// Shared widths, types and frame-state encoding for the MAC accumulate stage.
package mac_pkg;

   localparam int MAC_PROD_W = 36;
   localparam int MAC_ACC_W  = 44;
   localparam int MAC_CNT_W  = 8;

   typedef logic [MAC_PROD_W-1:0] prod_t;
   typedef logic [MAC_ACC_W-1:0]  acc_t;
   typedef logic [MAC_CNT_W-1:0]  cnt_t;

   typedef enum logic {
      ST_FIRST = 1'b0,
      ST_RUN   = 1'b1
   } frame_state_t;

endpackage

// File: rtl/mac_acc_adder.sv
// Combinational accumulate adder: acc + zext(prod) with carry out of ACC_W.
// MAC_SATURATE_EN: clamp the sum to all-ones on carry instead of wrapping.
module mac_acc_adder #(
   parameter int PROD_W = 36,
   parameter int ACC_W  = 44
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] prod,
   output logic [ACC_W-1:0]  sum,
   output logic              carry
);

   logic [ACC_W:0] raw;

   always_comb begin
      raw   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
      carry = raw[ACC_W];
`ifdef MAC_SATURATE_EN
      sum   = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
      sum   = raw[ACC_W-1:0];
`endif
   end

endmodule

// File: rtl/mac_accumulator.sv
// Frame accumulator: sums product beats up to prod_last, registered valid/ready result.
// Optional MAC_SATURATE_EN selects clamping instead of modulo wrap (see mac_acc_adder).
//
//  state    | meaning
//  ST_FIRST | next accepted beat opens a new frame
//  ST_RUN   | frame in progress, beats add into acc
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int PROD_W = MAC_PROD_W,
   parameter int ACC_W  = MAC_ACC_W,
   parameter int CNT_W  = MAC_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PROD_W-1:0] prod_in,
   input  logic              prod_valid,
   input  logic              prod_last,
   output logic              prod_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic [CNT_W-1:0]  term_count,
   output logic              overflow,
   output logic              acc_valid,
   input  logic              acc_ready
);

   logic [1:0]       rst_pipe;
   logic             rst_sync_n;
   frame_state_t     state, state_nxt;
   logic [ACC_W-1:0] acc, acc_base, sum;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             ovf, ovf_nxt, carry;
   logic             first, beat_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_pipe <= 2'b00;
      else        rst_pipe <= {rst_pipe[0], 1'b1};
   end
   assign rst_sync_n = rst_pipe[1];

   // Held low until reset release is synchronised so no beat is handshaken into held flops.
   assign prod_ready = rst_sync_n && (!acc_valid || acc_ready);
   assign beat_acc   = prod_valid && prod_ready;

   mac_acc_adder #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_adder (
      .acc   (acc_base),
      .prod  (prod_in),
      .sum   (sum),
      .carry (carry)
   );

   always_comb begin
      state_nxt = state;
      first     = (state == ST_FIRST);
      acc_base  = first ? '0 : acc;
      if (first)         cnt_nxt = CNT_W'(1);
      else if (&cnt)     cnt_nxt = cnt;
      else               cnt_nxt = cnt + 1'b1;
      ovf_nxt   = (!first && ovf) || carry;
      if (beat_acc) state_nxt = prod_last ? ST_FIRST : ST_RUN;
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) state <= ST_FIRST;
      else             state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (beat_acc) begin
         acc <= sum;
         cnt <= cnt_nxt;
         ovf <= ovf_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         acc_out    <= '0;
         term_count <= '0;
         overflow   <= 1'b0;
         acc_valid  <= 1'b0;
      end else if (beat_acc && prod_last) begin
         acc_out    <= sum;
         term_count <= cnt_nxt;
         overflow   <= ovf_nxt;
         acc_valid  <= 1'b1;
      end else if (acc_ready) begin
         acc_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: directed frames plus randomized traffic.
module tb_mac_accumulator;
   import mac_pkg::*;

   localparam int PW   = MAC_PROD_W;
   localparam int AW   = MAC_ACC_W;
   localparam int CW   = MAC_CNT_W;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [PW-1:0] prod_in = '0;
   logic          prod_valid = 1'b0;
   logic          prod_last = 1'b0;
   logic          prod_ready;
   logic [AW-1:0] acc_out;
   logic [CW-1:0] term_count;
   logic          overflow;
   logic          acc_valid;
   logic          acc_ready = 1'b1;

   always #5 clk = ~clk;

   mac_accumulator dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .prod_in    (prod_in),
      .prod_valid (prod_valid),
      .prod_last  (prod_last),
      .prod_ready (prod_ready),
      .acc_out    (acc_out),
      .term_count (term_count),
      .overflow   (overflow),
      .acc_valid  (acc_valid),
      .acc_ready  (acc_ready)
   );

   typedef struct packed {
      logic [AW-1:0] acc;
      logic [CW-1:0] cnt;
      logic          ovf;
   } res_t;

   res_t          exp_q[$];
   logic [PW-1:0] frm[$];
   int            total = 0;
   int            bad = 0;
   int            pushed = 0;
   int            popped = 0;
   bit            rnd_ready = 1'b0;
   bit            gap_en = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", name, got, want);
      end
   endtask

   // Reference: true arithmetic sum of the frame, then wrap or clamp at 2^AW.
   function automatic res_t model();
      longint unsigned s = 0;
      res_t r;
      foreach (frm[i]) s += 64'(frm[i]);
      r.ovf = (s > ((64'd1 << AW) - 1));
`ifdef MAC_SATURATE_EN
      r.acc = r.ovf ? {AW{1'b1}} : AW'(s);
`else
      r.acc = AW'(s);
`endif
      r.cnt = (frm.size() > CMAX) ? CW'(CMAX) : CW'(frm.size());
      return r;
   endfunction

   always @(negedge clk) begin : monitor
      res_t e;
      if (rst_n && acc_valid && acc_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got acc_out=%0d want no result", acc_out);
         end else begin
            e = exp_q.pop_front();
            popped++;
            check("sb_acc_out", 64'(acc_out), 64'(e.acc));
            check("sb_term_count", 64'(term_count), 64'(e.cnt));
            check("sb_overflow", 64'(overflow), 64'(e.ovf));
         end
      end
   end

   initial begin : ready_randomizer
      forever begin
         @(posedge clk);
         #2;
         if (rnd_ready) acc_ready = ($urandom_range(3, 0) != 0);
      end
   end

   task automatic drive_beat(input logic [PW-1:0] d, input logic last);
      bit acc;
      if (gap_en && $urandom_range(3, 0) == 0)
         repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
      prod_in    = d;
      prod_last  = last;
      prod_valid = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 1000 && !acc; c++) begin
         @(negedge clk);
         acc = prod_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL beat_timeout: got prod_ready=0 want 1 within 1000 cycles");
      end
      prod_valid = 1'b0;
      prod_last  = 1'b0;
   endtask

   task automatic run_frame();
      exp_q.push_back(model());
      pushed++;
      foreach (frm[i]) drive_beat(frm[i], i == frm.size() - 1);
   endtask

   task automatic drain();
      int c = 0;
      while (exp_q.size() != 0 && c < 2000) begin
         @(posedge clk);
         c++;
      end
      #1;
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      check("valid_cleared", 64'(acc_valid), 64'd0);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: got timeout want completion");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

   initial begin : stim
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_acc_out", 64'(acc_out), 64'd0);
      check("rst_term_count", 64'(term_count), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_acc_valid", 64'(acc_valid), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // 1: two-beat frame, result one edge after the last beat
      frm = '{36'hFE010000, 36'd1268108266};
      run_frame();
      check("t1_latency_valid", 64'(acc_valid), 64'd1);
      check("t1_acc_out", 64'(acc_out), 64'd5529586666);
      check("t1_term_count", 64'(term_count), 64'd2);
      drain();

      // 2: single-beat frame
      frm = '{36'd1268108266};
      run_frame();
      check("t2_acc_out", 64'(acc_out), 64'd1268108266);
      check("t2_term_count", 64'(term_count), 64'd1);
      drain();

      // 3: stalled result, then pop together with a new last beat
      acc_ready = 1'b0;
      frm = '{36'd7, 36'd9};
      run_frame();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t3_stall_prod_ready", 64'(prod_ready), 64'd0);
         check("t3_stall_valid", 64'(acc_valid), 64'd1);
         check("t3_stall_acc_out", 64'(acc_out), 64'd16);
         check("t3_stall_term_count", 64'(term_count), 64'd2);
      end
      @(posedge clk); #1;
      acc_ready = 1'b1;
      frm = '{36'd33};
      run_frame();
      check("t3_b2b_valid", 64'(acc_valid), 64'd1);
      check("t3_b2b_acc_out", 64'(acc_out), 64'd33);
      drain();

      // 4: long frame of max products, counter saturates and sum overflows
      frm.delete();
      for (int i = 0; i < 257; i++) frm.push_back({PW{1'b1}});
      run_frame();
      check("t4_term_count", 64'(term_count), 64'd255);
      check("t4_overflow", 64'(overflow), 64'd1);
`ifdef MAC_SATURATE_EN
      check("t4_acc_out", 64'(acc_out), 64'hFFFFFFFFFFF);
`else
      check("t4_acc_out", 64'(acc_out), 64'd68719476479);
`endif
      drain();

      // 5: reset mid-frame discards the partial sum
      for (int i = 0; i < 3; i++) drive_beat(36'd100, 1'b0);
      rst_n = 1'b0;
      #1;
      check("t5_rst_acc_out", 64'(acc_out), 64'd0);
      check("t5_rst_term_count", 64'(term_count), 64'd0);
      check("t5_rst_overflow", 64'(overflow), 64'd0);
      check("t5_rst_acc_valid", 64'(acc_valid), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      frm = '{36'd7};
      run_frame();
      check("t5_acc_out", 64'(acc_out), 64'd7);
      check("t5_term_count", 64'(term_count), 64'd1);
      drain();

      // 6: random traffic with gaps on both sides
      rnd_ready = 1'b1;
      gap_en    = 1'b1;
      for (int f = 0; f < 1000; f++) begin
         int n;
         bit big;
         big = (f % 100 == 99);
         n = big ? $urandom_range(300, 250) : $urandom_range(8, 1);
         frm.delete();
         for (int i = 0; i < n; i++) begin
            if (big) frm.push_back({20'hFFFFF, 16'($urandom)});
            else     frm.push_back({4'($urandom_range(15, 0)), 32'($urandom)});
         end
         run_frame();
      end
      @(posedge clk); #1;
      rnd_ready = 1'b0;
      acc_ready = 1'b1;
      drain();
      check("t6_results_count", 64'(popped), 64'(pushed));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
